// File: rtl/trap_controller.sv
// Trap controller: sequences reset-vector exit, fetch/execute exception entry,
// mret return and double-fault halt, and holds the trap CSRs.
`ifndef TRAP_CODES_DEFINED
`define TRAP_CODES_DEFINED
`define E_FETCH_ADDR_MISALIGNED 4'd0
`define E_ILLEGAL_INSTR         4'd2
`define E_LOAD_ADDR_MISALIGNED  4'd4
`define E_LOAD_ACCESS_FAULT     4'd5
`define E_STORE_ADDR_MISALIGNED 4'd6
`define E_STORE_ACCESS_FAULT    4'd7
`define E_ECALL                 4'd11
`define E_SP_OUT_OF_RANGE       4'd14
`define NO_E                    4'd15
`endif

module trap_controller #(
    parameter logic [31:0] P_TRAP_BASE    = 32'h0000_0000,
    parameter logic [2:0]  P_TEXT_REGION  = 3'b010,
    parameter int unsigned P_DRAIN_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_exception_code_f,
    input  logic [31:0] i_pc_f,
    input  logic [3:0]  i_exception_code_e,
    input  logic [31:0] i_pc_e,
    input  logic [31:0] i_alu_out_e,
    input  logic        i_mret_e,
    output logic        o_reset_permission,
    output logic        o_trap_permission,
    output logic        o_redirect_en,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush_fd,
    output logic        o_flush_de,
    output logic        o_stall_f,
    output logic [3:0]  o_mcause,
    output logic [31:0] o_mepc,
    output logic [31:0] o_mtval,
    output logic        o_halt
);

    localparam int unsigned CNT_W = (P_DRAIN_CYCLES < 1) ? 1 : $clog2(P_DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {S_RESETV, S_RUN, S_DRAIN, S_TRAP, S_HALT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         pend_code_q, pend_code_d;
    logic [31:0]        pend_pc_q, pend_pc_d;
    logic [31:0]        pend_tval_q, pend_tval_d;
    logic [3:0]         mcause_q, mcause_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mtval_q, mtval_d;

    logic               e_exc, f_exc, take_trap;
    logic [3:0]         trap_code;
    logic [31:0]        trap_pc, trap_tval;

    function automatic logic [31:0] tval_sel(input logic [3:0] code, input logic [31:0] pc,
                                             input logic [31:0] addr);
        case (code)
            `E_FETCH_ADDR_MISALIGNED, `E_ILLEGAL_INSTR: tval_sel = pc;
            `E_LOAD_ADDR_MISALIGNED, `E_LOAD_ACCESS_FAULT,
            `E_STORE_ADDR_MISALIGNED, `E_STORE_ACCESS_FAULT,
            `E_SP_OUT_OF_RANGE:                         tval_sel = addr;
            default:                                    tval_sel = '0;
        endcase
    endfunction

    assign e_exc = (i_exception_code_e != `NO_E);
    assign f_exc = (i_exception_code_f != `NO_E);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_code_d   = pend_code_q;
        pend_pc_d     = pend_pc_q;
        pend_tval_d   = pend_tval_q;
        mcause_d      = mcause_q;
        mepc_d        = mepc_q;
        mtval_d       = mtval_q;
        o_redirect_en = 1'b0;
        o_redirect_pc = P_TRAP_BASE;
        o_flush_fd    = 1'b0;
        o_flush_de    = 1'b0;
        o_stall_f     = 1'b0;
        take_trap     = 1'b0;
        trap_code     = i_exception_code_e;
        trap_pc       = i_pc_e;
        trap_tval     = tval_sel(i_exception_code_e, i_pc_e, i_alu_out_e);

        case (state_q)
            S_RESETV: begin
                if (i_pc_f[20:18] == P_TEXT_REGION) state_d = S_RUN;
            end
            S_RUN: begin
                if (e_exc) begin
                    take_trap = 1'b1;
                end else if (f_exc) begin
                    pend_code_d = i_exception_code_f;
                    pend_pc_d   = i_pc_f;
                    pend_tval_d = tval_sel(i_exception_code_f, i_pc_f, i_alu_out_e);
                    cnt_d       = CNT_W'(P_DRAIN_CYCLES);
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                o_stall_f  = 1'b1;
                o_flush_fd = 1'b1;
                if (e_exc) begin
                    take_trap = 1'b1;
                end else if (cnt_q == '0) begin
                    take_trap = 1'b1;
                    trap_code = pend_code_q;
                    trap_pc   = pend_pc_q;
                    trap_tval = pend_tval_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_TRAP: begin
                if (e_exc) begin
                    state_d = S_HALT;
                end else if (i_mret_e) begin
                    o_redirect_en = 1'b1;
                    o_redirect_pc = mepc_q;
                    o_flush_fd    = 1'b1;
                    o_flush_de    = 1'b1;
                    state_d       = S_RUN;
                end
            end
            S_HALT: begin
                o_stall_f  = 1'b1;
                o_flush_fd = 1'b1;
                o_flush_de = 1'b1;
            end
            default: state_d = S_RESETV;
        endcase

        // Any trap entry retires the pending fetch exception, whether taken or pre-empted by E.
        if (take_trap) begin
            o_redirect_en = 1'b1;
            o_redirect_pc = P_TRAP_BASE;
            o_flush_fd    = 1'b1;
            o_flush_de    = 1'b1;
            mcause_d      = trap_code;
            mepc_d        = trap_pc;
            mtval_d       = trap_tval;
            pend_code_d   = `NO_E;
            cnt_d         = '0;
            state_d       = S_TRAP;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_RESETV;
            cnt_q       <= '0;
            pend_code_q <= `NO_E;
            pend_pc_q   <= '0;
            pend_tval_q <= '0;
            mcause_q    <= `NO_E;
            mepc_q      <= '0;
            mtval_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_code_q <= pend_code_d;
            pend_pc_q   <= pend_pc_d;
            pend_tval_q <= pend_tval_d;
            mcause_q    <= mcause_d;
            mepc_q      <= mepc_d;
            mtval_q     <= mtval_d;
        end
    end

    assign o_reset_permission = (state_q == S_RESETV);
    assign o_trap_permission  = (state_q == S_TRAP);
    assign o_halt             = (state_q == S_HALT);
    assign o_mcause           = mcause_q;
    assign o_mepc             = mepc_q;
    assign o_mtval            = mtval_q;

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed scenarios then random traffic, all
// outputs compared every cycle against a flag-based behavioural model.
`ifndef TRAP_CODES_DEFINED
`define TRAP_CODES_DEFINED
`define E_FETCH_ADDR_MISALIGNED 4'd0
`define E_ILLEGAL_INSTR         4'd2
`define E_LOAD_ADDR_MISALIGNED  4'd4
`define E_LOAD_ACCESS_FAULT     4'd5
`define E_STORE_ADDR_MISALIGNED 4'd6
`define E_STORE_ACCESS_FAULT    4'd7
`define E_ECALL                 4'd11
`define E_SP_OUT_OF_RANGE       4'd14
`define NO_E                    4'd15
`endif

module tb_trap_controller;

    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  code_f, code_e;
    logic [31:0] pc_f, pc_e, alu;
    logic        mret;
    logic        reset_perm, trap_perm, redir_en, flush_fd, flush_de, stall_f, halt;
    logic [31:0] redir_pc, mepc, mtval;
    logic [3:0]  mcause;

    int vectors = 0;
    int miscompares = 0;

    trap_controller #(.P_TRAP_BASE(32'h0000_0000), .P_TEXT_REGION(3'b010),
                      .P_DRAIN_CYCLES(DRAIN)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_exception_code_f(code_f), .i_pc_f(pc_f),
        .i_exception_code_e(code_e), .i_pc_e(pc_e), .i_alu_out_e(alu), .i_mret_e(mret),
        .o_reset_permission(reset_perm), .o_trap_permission(trap_perm),
        .o_redirect_en(redir_en), .o_redirect_pc(redir_pc),
        .o_flush_fd(flush_fd), .o_flush_de(flush_de), .o_stall_f(stall_f),
        .o_mcause(mcause), .o_mepc(mepc), .o_mtval(mtval), .o_halt(halt)
    );

    always #5 clk = ~clk;

    // Model: the machine is described by flags and a countdown, not a state code.
    bit          booted, trapped, halted;
    int          drain_left;
    logic [3:0]  p_code, m_cause;
    logic [31:0] p_pc, p_tval, m_epc, m_tval;
    bit          n_booted, n_trapped, n_halted;
    int          n_drain;
    logic [3:0]  n_p_code, n_cause;
    logic [31:0] n_p_pc, n_p_tval, n_epc, n_tval;
    logic        x_red, x_ffd, x_fde, x_stall;
    logic [31:0] x_rpc;

    logic [3:0] codes [8] = '{`E_FETCH_ADDR_MISALIGNED, `E_ILLEGAL_INSTR, `E_LOAD_ADDR_MISALIGNED,
                              `E_LOAD_ACCESS_FAULT, `E_STORE_ADDR_MISALIGNED,
                              `E_STORE_ACCESS_FAULT, `E_ECALL, `E_SP_OUT_OF_RANGE};

    function automatic logic [31:0] tval_of(input logic [3:0] c, input logic [31:0] pc,
                                            input logic [31:0] a);
        if (c == `E_FETCH_ADDR_MISALIGNED || c == `E_ILLEGAL_INSTR) return pc;
        if (c == `E_ECALL) return 32'h0;
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        booted = 0; trapped = 0; halted = 0; drain_left = -1;
        p_code = `NO_E; p_pc = '0; p_tval = '0;
        m_cause = `NO_E; m_epc = '0; m_tval = '0;
    endtask

    task automatic enter_trap(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] tv);
        x_red = 1; x_rpc = 32'h0; x_ffd = 1; x_fde = 1;
        n_cause = c; n_epc = pc; n_tval = tv;
        n_trapped = 1; n_drain = -1; n_p_code = `NO_E;
    endtask

    task automatic idle();
        code_f = `NO_E; code_e = `NO_E; mret = 0;
    endtask

    // One cycle: settle, predict and compare, clock, commit, return at negedge.
    task automatic step();
        #1;
        x_red = 0; x_rpc = 32'h0; x_ffd = 0; x_fde = 0; x_stall = 0;
        n_booted = booted; n_trapped = trapped; n_halted = halted; n_drain = drain_left;
        n_p_code = p_code; n_p_pc = p_pc; n_p_tval = p_tval;
        n_cause = m_cause; n_epc = m_epc; n_tval = m_tval;
        if (!booted) begin
            if (pc_f[20:18] == 3'b010) n_booted = 1;
        end else if (halted) begin
            x_stall = 1; x_ffd = 1; x_fde = 1;
        end else if (trapped) begin
            if (code_e != `NO_E) begin
                n_halted = 1; n_trapped = 0;
            end else if (mret) begin
                x_red = 1; x_rpc = m_epc; x_ffd = 1; x_fde = 1; n_trapped = 0;
            end
        end else begin
            if (drain_left >= 0) begin x_stall = 1; x_ffd = 1; end
            if (code_e != `NO_E)      enter_trap(code_e, pc_e, tval_of(code_e, pc_e, alu));
            else if (drain_left == 0) enter_trap(p_code, p_pc, p_tval);
            else if (drain_left > 0)  n_drain = drain_left - 1;
            else if (code_f != `NO_E) begin
                n_drain = DRAIN; n_p_code = code_f; n_p_pc = pc_f;
                n_p_tval = tval_of(code_f, pc_f, alu);
            end
        end
        chk("redirect_en", 32'(redir_en), 32'(x_red));
        if (x_red) chk("redirect_pc", redir_pc, x_rpc);
        chk("flush_fd", 32'(flush_fd), 32'(x_ffd));
        chk("flush_de", 32'(flush_de), 32'(x_fde));
        chk("stall_f", 32'(stall_f), 32'(x_stall));
        chk("reset_perm", 32'(reset_perm), 32'(!booted));
        chk("trap_perm", 32'(trap_perm), 32'(trapped));
        chk("halt", 32'(halt), 32'(halted));
        chk("mcause", 32'(mcause), 32'(m_cause));
        chk("mepc", mepc, m_epc);
        chk("mtval", mtval, m_tval);
        @(posedge clk);
        booted = n_booted; trapped = n_trapped; halted = n_halted; drain_left = n_drain;
        p_code = n_p_code; p_pc = n_p_pc; p_tval = n_p_tval;
        m_cause = n_cause; m_epc = n_epc; m_tval = n_tval;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        chk("rst_reset_perm", 32'(reset_perm), 32'd1);
        chk("rst_trap_perm", 32'(trap_perm), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_mcause", 32'(mcause), 32'(`NO_E));
        chk("rst_mepc", mepc, 32'h0);
        chk("rst_mtval", mtval, 32'h0);
        chk("rst_strobes", {28'h0, redir_en, flush_fd, flush_de, stall_f}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int stalls;
        idle(); pc_f = 32'h0; pc_e = 32'h0; alu = 32'h0;
        rst_n = 1;
        @(negedge clk);
        do_reset();

        // Leave the reset vector only from the text region
        step();
        pc_f = 32'h0008_0000; step();
        step();
        chk("boot_reset_perm", 32'(reset_perm), 32'd0);

        // Execute-stage load access fault
        code_e = `E_LOAD_ACCESS_FAULT; pc_e = 32'h0008_0010; alu = 32'h0000_0123;
        step();
        idle(); step();
        chk("ld_mcause", 32'(mcause), 32'(`E_LOAD_ACCESS_FAULT));
        chk("ld_mtval", mtval, 32'h0000_0123);
        chk("ld_trap_perm", 32'(trap_perm), 32'd1);
        mret = 1; step();
        idle(); step();

        // Fetch-stage illegal instruction drains before entry
        code_f = `E_ILLEGAL_INSTR; pc_f = 32'h0008_0020; step();
        idle(); stalls = 0;
        for (int i = 0; i < DRAIN + 1; i++) begin
            #1; if (stall_f) stalls++;
            step();
        end
        chk("drain_stalls", 32'(stalls), 32'(DRAIN + 1));
        chk("f_mepc", mepc, 32'h0008_0020);
        chk("f_mtval", mtval, 32'h0008_0020);
        mret = 1; step(); idle();

        // E exception pre-empts a pending F exception
        code_f = `E_ILLEGAL_INSTR; pc_f = 32'h0008_0030; step();
        idle(); step();
        code_e = `E_ECALL; pc_e = 32'h0008_0018; step();
        idle(); for (int i = 0; i < 4; i++) step();
        chk("ecall_mcause", 32'(mcause), 32'(`E_ECALL));
        chk("ecall_mepc", mepc, 32'h0008_0018);
        chk("ecall_mtval", mtval, 32'h0);
        mret = 1; step(); idle();

        // Simultaneous E and F in run: E wins
        code_e = `E_SP_OUT_OF_RANGE; pc_e = 32'h0008_0040; alu = 32'h7fff_fff0;
        code_f = `E_FETCH_ADDR_MISALIGNED; pc_f = 32'h0008_0044; step();
        idle(); for (int i = 0; i < 4; i++) step();
        mret = 1; step(); idle();

        // mret return, then double fault (with mret) halts until reset
        code_e = `E_LOAD_ACCESS_FAULT; pc_e = 32'h0008_0010; step();
        idle(); mret = 1; step();
        idle(); code_e = `E_STORE_ACCESS_FAULT; pc_e = 32'h0008_0050; step();
        idle(); mret = 1; code_e = `E_ECALL; step();
        idle(); for (int i = 0; i < 3; i++) step();
        chk("halt_held", 32'(halt), 32'd1);
        do_reset();
        step();

        // Reset in the middle of a drain
        pc_f = 32'h0008_0000; step();
        code_f = `E_ILLEGAL_INSTR; step();
        idle(); step();
        do_reset();
        pc_f = 32'h0; for (int i = 0; i < 3; i++) step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            code_e = ($urandom_range(0, 7) == 0) ? codes[$urandom_range(0, 7)] : `NO_E;
            code_f = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 7)] : `NO_E;
            mret   = ($urandom_range(0, 3) == 0);
            pc_f   = $urandom; pc_e = $urandom; alu = $urandom;
            if ($urandom_range(0, 79) == 0) do_reset();
            step();
        end
        idle(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 Parameter P_TRAP_BASE, 32'h0000_0000, redirect target on trap entry (trap-vector region, pc[20:18]=000).
REQ-002 Parameter P_TEXT_REGION, 3'b010, pc[20:18] value marking the text region.
REQ-003 Parameter P_DRAIN_CYCLES, 2, cycles a pending fetch exception waits for older instructions to leave E.
REQ-004 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_exception_code_f  in  4  fetch-stage exception code; `NO_E means none.
REQ-007 i_pc_f  in  32  fetch PC.
REQ-008 i_exception_code_e  in  4  execute-stage exception code; `NO_E means none.
REQ-009 i_pc_e  in  32  PC of the instruction in E.
REQ-010 i_alu_out_e  in  32  E-stage effective address / ALU result.
REQ-011 i_mret_e  in  1  mret in E.
REQ-012 o_reset_permission, o_trap_permission  out  1 each  region permissions fed back to the exception detector.
REQ-013 o_redirect_en  out  1  PC override strobe; o_redirect_pc  out  32  override target.
REQ-014 o_flush_fd, o_flush_de  out  1 each  bubble the F/D and D/E pipeline registers.
REQ-015 o_stall_f  out  1  hold the fetch PC.
REQ-016 o_mcause  out  4; o_mepc  out  32; o_mtval  out  32  trap CSR values.
REQ-017 o_halt  out  1  double-fault indication.

Function
REQ-018 States: S_RESETV, S_RUN, S_DRAIN, S_TRAP, S_HALT; encoding is free.
REQ-019 S_RESETV: o_reset_permission=1; when i_pc_f[20:18]==P_TEXT_REGION, the next state is S_RUN.
REQ-020 S_RUN or S_DRAIN with i_exception_code_e!=`NO_E: trap entry.
  - Same cycle: o_redirect_en=1, o_redirect_pc=P_TRAP_BASE, o_flush_fd=o_flush_de=1.
  - Next edge: o_mcause<=code_e, o_mepc<=i_pc_e, state<=S_TRAP.
REQ-021 S_RUN with only i_exception_code_f!=`NO_E: latch the pending code, i_pc_f and mtval; load the drain counter with P_DRAIN_CYCLES; state<=S_DRAIN.
REQ-022 S_DRAIN: o_stall_f=1 and o_flush_fd=1 every cycle; the counter decrements each cycle.
  - At counter==0 with no E exception: trap entry per REQ-020, using the pending code/PC/mtval.
REQ-023 Simultaneous E and F exceptions, or an E exception during S_DRAIN: the E exception wins; the pending F exception is discarded.
REQ-024 mtval selection:
  - `E_FETCH_ADDR_MISALIGNED, `E_ILLEGAL_INSTR: faulting PC.
  - Load/store misaligned/fault, `E_SP_OUT_OF_RANGE: i_alu_out_e.
  - `E_ECALL: 0.
REQ-025 S_TRAP: o_trap_permission=1.
  - i_mret_e=1 with no E exception: same cycle o_redirect_en=1, o_redirect_pc=o_mepc, o_flush_fd=o_flush_de=1; next state S_RUN.
REQ-026 S_TRAP with any i_exception_code_e!=`NO_E (including simultaneous with mret): next state S_HALT; the CSRs are not updated; F exceptions are ignored in S_TRAP.
REQ-027 S_HALT: o_halt=1, o_stall_f=1, o_flush_fd=o_flush_de=1 continuously; exit only by reset.
REQ-028 i_mret_e outside S_TRAP is ignored.
REQ-029 o_redirect_en, o_flush_*, o_stall_f are combinational from state and inputs; permissions, CSRs and o_halt are registered.

Reset
REQ-030 On i_rst_n=0, regardless of state (including mid-drain):
  - state=S_RESETV, o_reset_permission=1, o_trap_permission=0, o_halt=0.
  - o_mcause=`NO_E, o_mepc=0, o_mtval=0; pending F exception and drain counter cleared.
  - All strobes 0.

Verification
REQ-031 Reset, then i_pc_f=32'h0008_0000 -> o_reset_permission 1 then 0 after one edge; state S_RUN.
REQ-032 S_RUN, i_exception_code_e=`E_LOAD_ACCESS_FAULT, i_pc_e=32'h0008_0010, i_alu_out_e=32'h0000_0123 -> same cycle redirect to 0x0 with both flushes; next cycle mcause=`E_LOAD_ACCESS_FAULT, mepc=0x0008_0010, mtval=0x123, o_trap_permission=1.
REQ-033 S_RUN, F exception `E_ILLEGAL_INSTR at i_pc_f=32'h0008_0020 -> o_stall_f=1 for 3 cycles, then trap entry with mepc=mtval=0x0008_0020.
REQ-034 F exception pending; one cycle later E exception `E_ECALL at i_pc_e=32'h0008_0018 -> mcause=`E_ECALL, mepc=0x0008_0018, mtval=0; the F exception is never taken.
REQ-035 S_TRAP with mepc=0x0008_0010: i_mret_e=1 -> redirect to 0x0008_0010, trap permission clears; repeat with E exception during S_TRAP -> o_halt=1 until i_rst_n pulses low.
